// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and state type for the read arbiter slice.
// Imported by the arbiter top and its round-robin grant sub-module.
package axi4_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } rd_arb_state_t;

endpackage

// File: rtl/axi4_read_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant: on a tie the requester not served last wins.
// last_grant only moves when the caller reports a completed transfer.
module rr_arbiter2
    import axi4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       upd,
    input  logic       upd_idx,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic last_grant;

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (upd) begin
            last_grant <= upd_idx;
        end
    end

    always_comb begin
        gnt_valid = en && (req != 2'b00);
        gnt_idx   = (req == 2'b11) ? ~last_grant : req[1];
    end

endmodule

// File: rtl/axi4_read_arbiter.sv
// Shares one AXI4 read master (AR/R) between two requesters, one burst at a time,
// with round-robin grant and a sticky RLAST/ARLEN mismatch flag.
module axi4_read_arbiter
    import axi4_pkg::*;
#(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,

    input  logic [C_M_AXI_ID_WIDTH-1:0]   S0_AXI_ARID,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] S0_AXI_ARADDR,
    input  logic [7:0]                    S0_AXI_ARLEN,
    input  logic [2:0]                    S0_AXI_ARSIZE,
    input  logic [1:0]                    S0_AXI_ARBURST,
    input  logic                          S0_AXI_ARVALID,
    output logic                          S0_AXI_ARREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]   S0_AXI_RID,
    output logic [C_M_AXI_DATA_WIDTH-1:0] S0_AXI_RDATA,
    output logic [1:0]                    S0_AXI_RRESP,
    output logic                          S0_AXI_RLAST,
    output logic                          S0_AXI_RVALID,
    input  logic                          S0_AXI_RREADY,

    input  logic [C_M_AXI_ID_WIDTH-1:0]   S1_AXI_ARID,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] S1_AXI_ARADDR,
    input  logic [7:0]                    S1_AXI_ARLEN,
    input  logic [2:0]                    S1_AXI_ARSIZE,
    input  logic [1:0]                    S1_AXI_ARBURST,
    input  logic                          S1_AXI_ARVALID,
    output logic                          S1_AXI_ARREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]   S1_AXI_RID,
    output logic [C_M_AXI_DATA_WIDTH-1:0] S1_AXI_RDATA,
    output logic [1:0]                    S1_AXI_RRESP,
    output logic                          S1_AXI_RLAST,
    output logic                          S1_AXI_RVALID,
    input  logic                          S1_AXI_RREADY,

    output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                    M_AXI_ARLEN,
    output logic [2:0]                    M_AXI_ARSIZE,
    output logic [1:0]                    M_AXI_ARBURST,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RLAST,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,

    output logic                          LAST_ERR,
    output logic                          OWNER
);

    rd_arb_state_t state, next_state;

    logic                          owner;
    logic [7:0]                    beat_cnt;
    logic                          last_err;
    logic [C_M_AXI_ID_WIDTH-1:0]   ar_id;
    logic [C_M_AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                    ar_len;
    logic [2:0]                    ar_size;
    logic [1:0]                    ar_burst;

    logic gnt_valid, gnt_idx;
    logic in_data, own_rready, r_hs;

    assign in_data    = (state == DATA);
    assign own_rready = owner ? S1_AXI_RREADY : S0_AXI_RREADY;
    assign r_hs       = in_data && M_AXI_RVALID && own_rready;

    // Grant is gated by reset so no request is accepted while reset is held.
    rr_arbiter2 u_rr (
        .clk       (M_AXI_ACLK),
        .rst_n     (M_AXI_ARESETN),
        .req       ({S1_AXI_ARVALID, S0_AXI_ARVALID}),
        .en        ((state == IDLE) && M_AXI_ARESETN),
        .upd       (r_hs && M_AXI_RLAST),
        .upd_idx   (owner),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        S0_AXI_ARREADY = 1'b0;
        S1_AXI_ARREADY = 1'b0;
        unique case (state)
            IDLE: begin
                if (gnt_valid) begin
                    S0_AXI_ARREADY = !gnt_idx;
                    S1_AXI_ARREADY = gnt_idx;
                    next_state     = ADDR;
                end
            end
            ADDR: begin
                if (M_AXI_ARREADY) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (r_hs && M_AXI_RLAST) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            owner    <= 1'b0;
            ar_id    <= '0;
            ar_addr  <= '0;
            ar_len   <= '0;
            ar_size  <= '0;
            ar_burst <= '0;
        end else if ((state == IDLE) && gnt_valid) begin
            owner    <= gnt_idx;
            ar_id    <= gnt_idx ? S1_AXI_ARID    : S0_AXI_ARID;
            ar_addr  <= gnt_idx ? S1_AXI_ARADDR  : S0_AXI_ARADDR;
            ar_len   <= gnt_idx ? S1_AXI_ARLEN   : S0_AXI_ARLEN;
            ar_size  <= gnt_idx ? S1_AXI_ARSIZE  : S0_AXI_ARSIZE;
            ar_burst <= gnt_idx ? S1_AXI_ARBURST : S0_AXI_ARBURST;
        end
    end

    // beat_cnt is the index of the beat currently on the bus; it saturates.
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            beat_cnt <= '0;
            last_err <= 1'b0;
        end else if ((state == ADDR) && M_AXI_ARREADY) begin
            beat_cnt <= '0;
        end else if (r_hs) begin
            if (M_AXI_RLAST ? (beat_cnt != ar_len) : (beat_cnt == ar_len)) begin
                last_err <= 1'b1;
            end
            if (beat_cnt != '1) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

    assign M_AXI_ARID    = ar_id;
    assign M_AXI_ARADDR  = ar_addr;
    assign M_AXI_ARLEN   = ar_len;
    assign M_AXI_ARSIZE  = ar_size;
    assign M_AXI_ARBURST = ar_burst;
    assign M_AXI_ARVALID = (state == ADDR);

    assign M_AXI_RREADY  = in_data && own_rready;
    assign S0_AXI_RVALID = in_data && !owner && M_AXI_RVALID;
    assign S1_AXI_RVALID = in_data &&  owner && M_AXI_RVALID;

    assign S0_AXI_RID    = M_AXI_RID;
    assign S0_AXI_RDATA  = M_AXI_RDATA;
    assign S0_AXI_RRESP  = M_AXI_RRESP;
    assign S0_AXI_RLAST  = M_AXI_RLAST;
    assign S1_AXI_RID    = M_AXI_RID;
    assign S1_AXI_RDATA  = M_AXI_RDATA;
    assign S1_AXI_RRESP  = M_AXI_RRESP;
    assign S1_AXI_RLAST  = M_AXI_RLAST;

    assign LAST_ERR = last_err;
    assign OWNER    = owner;

endmodule

// File: tb/tb_axi4_read_arbiter.sv
// Directed bench for axi4_read_arbiter: a transaction-level model checked every
// cycle, plus literal expectations on grant order, latency, data and error flag.
module tb_axi4_read_arbiter;

    localparam int IW = 1;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          M_AXI_ARESETN = 1'b0;
    logic [IW-1:0] S0_AXI_ARID = '0, S1_AXI_ARID = '0;
    logic [AW-1:0] S0_AXI_ARADDR = '0, S1_AXI_ARADDR = '0;
    logic [7:0]    S0_AXI_ARLEN = '0, S1_AXI_ARLEN = '0;
    logic [2:0]    S0_AXI_ARSIZE = '0, S1_AXI_ARSIZE = '0;
    logic [1:0]    S0_AXI_ARBURST = '0, S1_AXI_ARBURST = '0;
    logic          S0_AXI_ARVALID = 1'b0, S1_AXI_ARVALID = 1'b0;
    logic          S0_AXI_ARREADY, S1_AXI_ARREADY;
    logic [IW-1:0] S0_AXI_RID, S1_AXI_RID;
    logic [DW-1:0] S0_AXI_RDATA, S1_AXI_RDATA;
    logic [1:0]    S0_AXI_RRESP, S1_AXI_RRESP;
    logic          S0_AXI_RLAST, S1_AXI_RLAST;
    logic          S0_AXI_RVALID, S1_AXI_RVALID;
    logic          S0_AXI_RREADY = 1'b0, S1_AXI_RREADY = 1'b0;
    logic [IW-1:0] M_AXI_ARID;
    logic [AW-1:0] M_AXI_ARADDR;
    logic [7:0]    M_AXI_ARLEN;
    logic [2:0]    M_AXI_ARSIZE;
    logic [1:0]    M_AXI_ARBURST;
    logic          M_AXI_ARVALID;
    logic          M_AXI_ARREADY = 1'b0;
    logic [IW-1:0] M_AXI_RID = '0;
    logic [DW-1:0] M_AXI_RDATA = '0;
    logic [1:0]    M_AXI_RRESP = '0;
    logic          M_AXI_RLAST = 1'b0;
    logic          M_AXI_RVALID = 1'b0;
    logic          M_AXI_RREADY;
    logic          LAST_ERR, OWNER;

    axi4_read_arbiter #(
        .C_M_AXI_ID_WIDTH  (IW),
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (M_AXI_ARESETN),
        .S0_AXI_ARID   (S0_AXI_ARID),   .S0_AXI_ARADDR (S0_AXI_ARADDR),
        .S0_AXI_ARLEN  (S0_AXI_ARLEN),  .S0_AXI_ARSIZE (S0_AXI_ARSIZE),
        .S0_AXI_ARBURST(S0_AXI_ARBURST),.S0_AXI_ARVALID(S0_AXI_ARVALID),
        .S0_AXI_ARREADY(S0_AXI_ARREADY),.S0_AXI_RID    (S0_AXI_RID),
        .S0_AXI_RDATA  (S0_AXI_RDATA),  .S0_AXI_RRESP  (S0_AXI_RRESP),
        .S0_AXI_RLAST  (S0_AXI_RLAST),  .S0_AXI_RVALID (S0_AXI_RVALID),
        .S0_AXI_RREADY (S0_AXI_RREADY),
        .S1_AXI_ARID   (S1_AXI_ARID),   .S1_AXI_ARADDR (S1_AXI_ARADDR),
        .S1_AXI_ARLEN  (S1_AXI_ARLEN),  .S1_AXI_ARSIZE (S1_AXI_ARSIZE),
        .S1_AXI_ARBURST(S1_AXI_ARBURST),.S1_AXI_ARVALID(S1_AXI_ARVALID),
        .S1_AXI_ARREADY(S1_AXI_ARREADY),.S1_AXI_RID    (S1_AXI_RID),
        .S1_AXI_RDATA  (S1_AXI_RDATA),  .S1_AXI_RRESP  (S1_AXI_RRESP),
        .S1_AXI_RLAST  (S1_AXI_RLAST),  .S1_AXI_RVALID (S1_AXI_RVALID),
        .S1_AXI_RREADY (S1_AXI_RREADY),
        .M_AXI_ARID    (M_AXI_ARID),    .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARLEN   (M_AXI_ARLEN),   .M_AXI_ARSIZE  (M_AXI_ARSIZE),
        .M_AXI_ARBURST (M_AXI_ARBURST), .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY), .M_AXI_RID     (M_AXI_RID),
        .M_AXI_RDATA   (M_AXI_RDATA),   .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RLAST   (M_AXI_RLAST),   .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY),
        .LAST_ERR      (LAST_ERR),
        .OWNER         (OWNER)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkw(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tfail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Transaction-level model: one burst in flight, who owns it, its request
    // fields, beats delivered so far, and who was last fully served.
    bit            m_busy, m_ar, m_owner, m_prev, m_err;
    int            m_len, m_beats;
    logic [IW-1:0] m_id;
    logic [AW-1:0] m_addr;
    logic [2:0]    m_size;
    logic [1:0]    m_burst;

    function automatic bit winner();
        if (S0_AXI_ARVALID && S1_AXI_ARVALID) return !m_prev;
        return S1_AXI_ARVALID;
    endfunction

    always @(posedge clk) begin
        if (!M_AXI_ARESETN) begin
            m_busy = 0; m_ar = 0; m_owner = 0; m_prev = 1; m_err = 0;
            m_len = 0; m_beats = 0;
        end else if (!m_busy) begin
            if (S0_AXI_ARVALID || S1_AXI_ARVALID) begin
                m_owner = winner();
                m_busy  = 1;
                m_ar    = 1;
                m_id    = m_owner ? S1_AXI_ARID    : S0_AXI_ARID;
                m_addr  = m_owner ? S1_AXI_ARADDR  : S0_AXI_ARADDR;
                m_len   = int'(m_owner ? S1_AXI_ARLEN : S0_AXI_ARLEN);
                m_size  = m_owner ? S1_AXI_ARSIZE  : S0_AXI_ARSIZE;
                m_burst = m_owner ? S1_AXI_ARBURST : S0_AXI_ARBURST;
            end
        end else if (m_ar) begin
            if (M_AXI_ARREADY) begin
                m_ar = 0;
                m_beats = 0;
            end
        end else if (M_AXI_RVALID && (m_owner ? S1_AXI_RREADY : S0_AXI_RREADY)) begin
            if (M_AXI_RLAST) begin
                if (m_beats != m_len) m_err = 1;
                m_busy = 0;
                m_prev = m_owner;
            end else if (m_beats == m_len) begin
                m_err = 1;
            end
            m_beats++;
        end
    end

    int rx0[$], rx1[$], glog[$], gcyc[$], rlcyc[$];

    always @(negedge clk) begin
        bit idle_req, w, in_data, own_rdy;
        if (chk_en) begin
            idle_req = M_AXI_ARESETN && !m_busy && (S0_AXI_ARVALID || S1_AXI_ARVALID);
            w        = winner();
            in_data  = m_busy && !m_ar;
            own_rdy  = m_owner ? S1_AXI_RREADY : S0_AXI_RREADY;
            chk1("s0_arready", S0_AXI_ARREADY, idle_req && !w);
            chk1("s1_arready", S1_AXI_ARREADY, idle_req && w);
            chk1("m_arvalid",  M_AXI_ARVALID,  m_busy && m_ar);
            if (m_busy && m_ar) begin
                chkw("m_araddr",  64'(M_AXI_ARADDR),  64'(m_addr));
                chkw("m_arlen",   64'(M_AXI_ARLEN),   64'(m_len));
                chkw("m_arid",    64'(M_AXI_ARID),    64'(m_id));
                chkw("m_arsize",  64'(M_AXI_ARSIZE),  64'(m_size));
                chkw("m_arburst", 64'(M_AXI_ARBURST), 64'(m_burst));
            end
            chk1("m_rready",  M_AXI_RREADY,  in_data && own_rdy);
            chk1("s0_rvalid", S0_AXI_RVALID, in_data && !m_owner && M_AXI_RVALID);
            chk1("s1_rvalid", S1_AXI_RVALID, in_data &&  m_owner && M_AXI_RVALID);
            chkw("s0_rdata",  64'(S0_AXI_RDATA), 64'(M_AXI_RDATA));
            chkw("s1_rdata",  64'(S1_AXI_RDATA), 64'(M_AXI_RDATA));
            chkw("s_rlast_rid_rresp",
                 64'({S0_AXI_RLAST, S1_AXI_RLAST, S0_AXI_RID, S1_AXI_RID, S0_AXI_RRESP, S1_AXI_RRESP}),
                 64'({M_AXI_RLAST, M_AXI_RLAST, M_AXI_RID, M_AXI_RID, M_AXI_RRESP, M_AXI_RRESP}));
            chk1("last_err", LAST_ERR, m_err);
            chk1("owner",    OWNER,    m_owner);

            if (S0_AXI_RVALID && S0_AXI_RREADY) rx0.push_back(int'(S0_AXI_RDATA));
            if (S1_AXI_RVALID && S1_AXI_RREADY) rx1.push_back(int'(S1_AXI_RDATA));
            if (S0_AXI_ARVALID && S0_AXI_ARREADY) begin glog.push_back(0); gcyc.push_back(cyc); end
            if (S1_AXI_ARVALID && S1_AXI_ARREADY) begin glog.push_back(1); gcyc.push_back(cyc); end
            if (M_AXI_RVALID && M_AXI_RREADY && M_AXI_RLAST) rlcyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rx0.delete(); rx1.delete(); glog.delete(); gcyc.delete(); rlcyc.delete();
    endtask

    task automatic do_reset();
        M_AXI_ARESETN  = 1'b0;
        S0_AXI_ARVALID = 1'b0; S1_AXI_ARVALID = 1'b0;
        S0_AXI_RREADY  = 1'b0; S1_AXI_RREADY  = 1'b0;
        M_AXI_ARREADY  = 1'b0; M_AXI_RVALID   = 1'b0; M_AXI_RLAST = 1'b0;
        tick();
        tick();
        M_AXI_ARESETN = 1'b1;
        clear_logs();
    endtask

    task automatic req0(input logic [AW-1:0] addr, input logic [7:0] len);
        S0_AXI_ARID = 1'b0; S0_AXI_ARADDR = addr; S0_AXI_ARLEN = len;
        S0_AXI_ARSIZE = 3'd2; S0_AXI_ARBURST = 2'b01; S0_AXI_ARVALID = 1'b1;
    endtask

    task automatic req1(input logic [AW-1:0] addr, input logic [7:0] len);
        S1_AXI_ARID = 1'b1; S1_AXI_ARADDR = addr; S1_AXI_ARLEN = len;
        S1_AXI_ARSIZE = 3'd3; S1_AXI_ARBURST = 2'b10; S1_AXI_ARVALID = 1'b1;
    endtask

    // Acts as the downstream slave for one burst: waits for the address, holds
    // ARREADY low ar_delay cycles, then sends nbeats beats with RLAST on beat
    // index last_at. The owner's RREADY optionally toggles; the other side is
    // driven to the opposite value so routing mistakes show up.
    task automatic serve(input int nbeats, input int last_at, input int ar_delay,
                         input bit toggle, input logic [1:0] drop, input logic [31:0] base);
        int t;
        int i;
        bit rr;
        bit own;
        t = 0;
        while (!M_AXI_ARVALID && t < 20) begin tick(); t++; end
        if (!M_AXI_ARVALID) tfail("arvalid_wait");
        if (drop[0]) S0_AXI_ARVALID = 1'b0;
        if (drop[1]) S1_AXI_ARVALID = 1'b0;
        for (int k = 0; k < ar_delay; k++) tick();
        M_AXI_ARREADY = 1'b1;
        tick();
        M_AXI_ARREADY = 1'b0;
        own = m_owner;
        i = 0; t = 0; rr = 1'b1;
        while (i < nbeats && t < 200) begin
            M_AXI_RVALID = 1'b1;
            M_AXI_RDATA  = base + 32'(i);
            M_AXI_RID    = own;
            M_AXI_RRESP  = 2'b00;
            M_AXI_RLAST  = (i == last_at);
            if (own) begin S1_AXI_RREADY = rr; S0_AXI_RREADY = !rr; end
            else     begin S0_AXI_RREADY = rr; S1_AXI_RREADY = !rr; end
            tick();
            t++;
            if (rr) i++;
            if (toggle) rr = !rr;
        end
        if (i < nbeats) tfail("beat_loop");
        M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
        S0_AXI_RREADY = 1'b0; S1_AXI_RREADY = 1'b0;
    endtask

    initial begin
        int seq3[6];
        seq3 = '{0, 1, 0, 1, 0, 1};

        tick();
        chk_en = 1'b1;
        do_reset();
        chk1("rst_m_arvalid", M_AXI_ARVALID, 1'b0);
        chk1("rst_m_rready",  M_AXI_RREADY,  1'b0);
        chk1("rst_last_err",  LAST_ERR,      1'b0);
        chk1("rst_owner",     OWNER,         1'b0);
        chk1("rst_s_rvalid",  S0_AXI_RVALID || S1_AXI_RVALID, 1'b0);

        // 1: single requester, 4-beat burst, one-cycle AR latency
        req0(32'h1000, 8'd3);
        #1 chk1("t1_s0_arready", S0_AXI_ARREADY, 1'b1);
        tick();
        chk1("t1_arvalid_n1", M_AXI_ARVALID, 1'b1);
        chkw("t1_araddr", 64'(M_AXI_ARADDR), 64'h1000);
        serve(4, 3, 0, 1'b0, 2'b01, 32'hA000);
        chkw("t1_rx0_count", 64'(rx0.size()), 64'd4);
        for (int k = 0; k < rx0.size(); k++) chkw("t1_rx0_data", 64'(rx0[k]), 64'(32'hA000 + k));
        chkw("t1_rx1_count", 64'(rx1.size()), 64'd0);
        chk1("t1_last_err", LAST_ERR, 1'b0);

        // 2: simultaneous request after reset, S0 then S1
        do_reset();
        req0(32'h2000, 8'd1);
        req1(32'h3000, 8'd2);
        serve(2, 1, 0, 1'b0, 2'b01, 32'hB000);
        serve(3, 2, 0, 1'b0, 2'b10, 32'hB100);
        chkw("t2_grants", 64'(glog.size()), 64'd2);
        if (glog.size() == 2) begin
            chkw("t2_first", 64'(glog[0]), 64'd0);
            chkw("t2_second", 64'(glog[1]), 64'd1);
            if (rlcyc.size() > 0) chkw("t2_regrant_cycle", 64'(gcyc[1]), 64'(rlcyc[0] + 1));
        end
        chkw("t2_rx1_count", 64'(rx1.size()), 64'd3);
        chk1("t2_owner", OWNER, 1'b1);

        // 3: both requesting continuously, grants alternate
        clear_logs();
        req0(32'h4000, 8'd1);
        req1(32'h5000, 8'd1);
        for (int k = 0; k < 6; k++) serve(2, 1, 0, 1'b0, (k == 5) ? 2'b11 : 2'b00, 32'hC000 + 32'(k * 16));
        chkw("t3_grants", 64'(glog.size()), 64'd6);
        for (int k = 0; k < glog.size() && k < 6; k++) chkw("t3_order", 64'(glog[k]), 64'(seq3[k]));

        // 4: slow ARREADY and toggling RREADY
        clear_logs();
        req0(32'h6000, 8'd3);
        serve(4, 3, 5, 1'b1, 2'b01, 32'hD000);
        chkw("t4_rx0_count", 64'(rx0.size()), 64'd4);
        for (int k = 0; k < rx0.size(); k++) chkw("t4_rx0_data", 64'(rx0[k]), 64'(32'hD000 + k));

        // 5: early RLAST, then sticky check, then missing RLAST, then ARLEN=0
        req0(32'h7000, 8'd3);
        serve(2, 1, 0, 1'b0, 2'b01, 32'hE000);
        chk1("t5_early_err", LAST_ERR, 1'b1);
        chk1("t5_idle_arvalid", M_AXI_ARVALID, 1'b0);
        req1(32'h7100, 8'd0);
        serve(1, 0, 0, 1'b0, 2'b10, 32'hE100);
        chk1("t5_sticky", LAST_ERR, 1'b1);
        do_reset();
        chk1("t5_rst_clears", LAST_ERR, 1'b0);
        req0(32'h7200, 8'd1);
        serve(3, 2, 0, 1'b0, 2'b01, 32'hE200);
        chk1("t5_late_err", LAST_ERR, 1'b1);
        do_reset();
        req0(32'h7300, 8'd0);
        serve(1, 0, 0, 1'b0, 2'b01, 32'hE300);
        chk1("t5_len0_ok", LAST_ERR, 1'b0);

        // 6: reset mid-burst; last_grant must return to its reset value
        req0(32'h8000, 8'd0);
        serve(1, 0, 0, 1'b0, 2'b01, 32'hF000);
        req1(32'h8100, 8'd7);
        serve(2, -1, 0, 1'b0, 2'b10, 32'hF100);
        M_AXI_RVALID  = 1'b1;
        S1_AXI_RREADY = 1'b1;
        M_AXI_ARESETN = 1'b0;
        tick();
        chk1("t6_m_rready",  M_AXI_RREADY,  1'b0);
        chk1("t6_s1_rvalid", S1_AXI_RVALID, 1'b0);
        chk1("t6_m_arvalid", M_AXI_ARVALID, 1'b0);
        chk1("t6_arready",   S0_AXI_ARREADY || S1_AXI_ARREADY, 1'b0);
        M_AXI_RVALID  = 1'b0;
        S1_AXI_RREADY = 1'b0;
        M_AXI_ARESETN = 1'b1;
        clear_logs();
        req0(32'h9000, 8'd0);
        req1(32'h9100, 8'd0);
        #1;
        chk1("t6_s0_first", S0_AXI_ARREADY, 1'b1);
        chk1("t6_s1_held",  S1_AXI_ARREADY, 1'b0);
        serve(1, 0, 0, 1'b0, 2'b11, 32'hF200);
        if (glog.size() > 0) chkw("t6_grant0", 64'(glog[0]), 64'd0);
        else tfail("t6_grant_log");
        tick();
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_read_arbiter.md
Name: axi4_read_arbiter

Overview:
Shares one AXI4 master read channel (AR/R) between two AXI4 read requesters, S0 and S1, using round-robin arbitration.
Only one burst is outstanding at a time. The owning requester keeps the R channel until RLAST.
The block sits upstream of axi4_read_write_merge's S_AXI_READ port, so several stream readers can share the single read side of a memory master.
Beat count is checked against ARLEN, and mismatches are reported on a sticky error flag.

Parameters:
C_M_AXI_ID_WIDTH, 1, ID width on all ports
C_M_AXI_ADDR_WIDTH, 32, address width
C_M_AXI_DATA_WIDTH, 32, data width

Ports:
M_AXI_ACLK  in  1  single clock for all ports
M_AXI_ARESETN  in  1  synchronous reset, active low
S{0,1}_AXI_ARID  in  ID_WIDTH  requester ARID
S{0,1}_AXI_ARADDR  in  ADDR_WIDTH  requester ARADDR
S{0,1}_AXI_ARLEN  in  8  requester ARLEN
S{0,1}_AXI_ARSIZE  in  3  requester ARSIZE
S{0,1}_AXI_ARBURST  in  2  requester ARBURST
S{0,1}_AXI_ARVALID  in  1  requester address valid
S{0,1}_AXI_ARREADY  out  1  requester address accepted
S{0,1}_AXI_RID / RDATA / RRESP / RLAST  out  ID_WIDTH / DATA_WIDTH / 2 / 1  read data fanned out from the M side
S{0,1}_AXI_RVALID  out  1  asserted only for the owning requester
S{0,1}_AXI_RREADY  in  1  requester data ready
M_AXI_ARID / ARADDR / ARLEN / ARSIZE / ARBURST  out  per S side  registered AR fields of the granted request
M_AXI_ARVALID  out  1  registered address valid
M_AXI_ARREADY  in  1  downstream address ready
M_AXI_RID / RDATA / RRESP / RLAST / RVALID  in  per S side  downstream read data
M_AXI_RREADY  out  1  downstream data ready
LAST_ERR  out  1  sticky RLAST/ARLEN mismatch flag
OWNER  out  1  index of the current/last granted requester

Behaviour:
- Clock and reset: one clock, M_AXI_ACLK. Reset is synchronous and active-low on M_AXI_ARESETN.
- Reset values: state=IDLE; M_AXI_ARVALID=0; all S ARREADY=0; all S RVALID=0; M_AXI_RREADY=0; LAST_ERR=0; last_grant=1, so S0 wins the first tie; OWNER=0; beat counter=0.
- States: IDLE, ADDR, DATA.
- IDLE, arbitration:
  - If exactly one S ARVALID is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - In the same cycle, the granted S_ARREADY is driven high combinationally, the AR fields are captured into the register, OWNER is set, and the state goes to ADDR.
  - The ungranted S_ARREADY stays 0.
- ADDR:
  - M_AXI_ARVALID=1 with the registered fields held stable.
  - When M_AXI_ARREADY=1, the state goes to DATA and the beat counter clears.
  - Latency: request accepted in cycle N, M_AXI_ARVALID first high in cycle N+1.
- DATA:
  - S[OWNER]_RVALID = M_AXI_RVALID; the other requester's RVALID=0.
  - M_AXI_RREADY = S[OWNER]_RREADY.
  - R payload is broadcast to both requesters.
  - Path is combinational, zero latency.
  - Each handshake increments the 8-bit beat counter.
- Burst completion: on a handshake with M_AXI_RLAST=1, the state goes to IDLE and last_grant=OWNER. The next grant can occur in the cycle after that.
- Error checks:
  - RLAST on a beat where count!=ARLEN sets LAST_ERR.
  - A beat at count==ARLEN without RLAST also sets LAST_ERR; the block keeps routing beats until RLAST arrives.
  - The counter saturates at 255; it never wraps.
- Outside DATA: M_AXI_RREADY=0 and both S RVALID=0, so stray R beats are back-pressured.
- S ARVALID is ignored in ADDR and DATA (S ARREADY=0).
- Reset mid-burst:
  - Returns immediately to IDLE and drops the burst.
  - The downstream slave must be reset by the same reset.
- ARLEN=0: a single-beat burst. RLAST on the first beat is correct, with no error.

Decomposition:
- Shared package axi4_pkg:
  - AXI_BURST_FIXED/INCR/WRAP constants
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants
  - rd_arb_state_t enum (IDLE, ADDR, DATA)
- One natural sub-module: rr_arbiter2, a two-requester round-robin grant with a last_grant register and a grant-enable input.

Test Plan:
1. Only S0 requests, ARADDR=0x1000, ARLEN=3 -> M ARVALID one cycle after S0 ARREADY; 4 beats reach S0 only; S1 RVALID stays 0; LAST_ERR=0.
2. S0 and S1 request in the same cycle right after reset -> S0 granted first; S1 granted in the cycle after S0's RLAST handshake; OWNER sequence 0,1.
3. S0 holds ARVALID continuously while S1 issues 3 back-to-back requests -> grants alternate 0,1,0,1,0,1.
4. M ARREADY held low 5 cycles, S0 RREADY toggling -> AR fields stable throughout; M RREADY mirrors S0 RREADY exactly; no beat lost or duplicated.
5. ARLEN=3, slave asserts RLAST on beat 2 -> LAST_ERR=1 and stays sticky; state returns to IDLE. Separate run: ARLEN=0 with RLAST on beat 1 -> LAST_ERR=0.
6. Reset asserted during DATA, beat 2 of 8 -> next cycle all valid/ready outputs 0 and state IDLE; the first grant after reset goes to S0.
